// File: rtl/phase_accumulator.sv
// NCO phase accumulator: phase/saw/square/wrap registered one cycle after a sample_en edge.
// Tuning words use valid/ready; tune_ready is low while a word is pending (one outstanding word).
module phase_accumulator #(
  parameter int PHASE_W = 24,
  parameter int TUNE_W  = 24,
  parameter int OUT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sample_en,
  input  logic               sync_clear,
  input  logic               tune_valid,
  output logic               tune_ready,
  input  logic [TUNE_W-1:0]  tune_word,
  input  logic               tune_mode,
  output logic [PHASE_W-1:0] phase,
  output logic [OUT_W-1:0]   saw,
  output logic               square,
  output logic               wrap
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PEND_SAMPLE = 2'd1,
    PEND_WRAP   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [PHASE_W-1:0]  phase_q, phase_d;
  logic [TUNE_W-1:0]   active_q, active_d;
  logic [TUNE_W-1:0]   pending_q, pending_d;
  logic                wrap_q, wrap_d;
  logic                tune_ready_q, tune_ready_d;

  logic [TUNE_W-1:0]   inc_word;
  logic [PHASE_W:0]    sum;
  logic                carry_evt;

  // A word pending for the next strobe is used by that very strobe.
  assign inc_word  = (state_q == PEND_SAMPLE) ? pending_q : active_q;
  assign sum       = {1'b0, phase_q} + {{(PHASE_W - TUNE_W + 1){1'b0}}, inc_word};
  assign carry_evt = sample_en && !sync_clear && sum[PHASE_W];

  always_comb begin
    phase_d   = phase_q;
    wrap_d    = 1'b0;
    active_d  = active_q;
    pending_d = pending_q;
    state_d   = state_q;

    if (sync_clear) begin
      phase_d = '0;
    end else if (sample_en) begin
      phase_d = sum[PHASE_W-1:0];
      wrap_d  = sum[PHASE_W];
    end

    case (state_q)
      IDLE: begin
        if (tune_valid) begin
          pending_d = tune_word;
          state_d   = tune_mode ? PEND_WRAP : PEND_SAMPLE;
        end
      end
      PEND_SAMPLE: begin
        if (sample_en) begin
          active_d = pending_q;
          state_d  = IDLE;
        end
      end
      PEND_WRAP: begin
        // With an active word of 0 this only leaves via sync_clear.
        if (carry_evt || sync_clear) begin
          active_d = pending_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    tune_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      phase_q      <= '0;
      active_q     <= '0;
      pending_q    <= '0;
      wrap_q       <= 1'b0;
      tune_ready_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      wrap_q       <= wrap_d;
      tune_ready_q <= tune_ready_d;
    end
  end

  assign tune_ready = tune_ready_q;
  assign phase      = phase_q;
  assign saw        = phase_q[PHASE_W-1 -: OUT_W];
  assign square     = phase_q[PHASE_W-1];
  assign wrap       = wrap_q;

endmodule

// File: tb/tb_phase_accumulator.sv
// Directed bench for phase_accumulator at PHASE_W=8, TUNE_W=8, OUT_W=4.
module tb_phase_accumulator;

  logic       clk;
  logic       rst_n;
  logic       sample_en;
  logic       sync_clear;
  logic       tune_valid;
  logic       tune_ready;
  logic [7:0] tune_word;
  logic       tune_mode;
  logic [7:0] phase;
  logic [3:0] saw;
  logic       square;
  logic       wrap;

  int n_cmp = 0;
  int n_bad = 0;

  phase_accumulator #(.PHASE_W(8), .TUNE_W(8), .OUT_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sample_en  (sample_en),
    .sync_clear (sync_clear),
    .tune_valid (tune_valid),
    .tune_ready (tune_ready),
    .tune_word  (tune_word),
    .tune_mode  (tune_mode),
    .phase      (phase),
    .saw        (saw),
    .square     (square),
    .wrap       (wrap)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] w, input logic m);
    int waited;
    waited = 0;
    while (!tune_ready && waited < 20) begin
      step();
      waited++;
    end
    if (!tune_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: tune_ready=%b required 1 within 20 cycles", tune_ready);
    end
    tune_valid = 1'b1;
    tune_word  = w;
    tune_mode  = m;
    step();
    tune_valid = 1'b0;
  endtask

  task automatic clear_phase();
    sample_en  = 1'b0;
    sync_clear = 1'b1;
    step();
    sync_clear = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++;
    if (phase !== 8'h00) begin n_bad++; $display("FAIL reset_phase: got %h want 00", phase); end
    n_cmp++;
    if (wrap !== 1'b0) begin n_bad++; $display("FAIL reset_wrap: got %b want 0", wrap); end
    n_cmp++;
    if (tune_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", tune_ready); end
    n_cmp++;
    if ({saw, square} !== 5'b0) begin n_bad++; $display("FAIL reset_saw_sq: got %h/%b want 0/0", saw, square); end
  endtask

  task automatic test_basic_wrap();
    logic [7:0] exp_ph [4];
    logic [3:0] exp_saw [4];
    logic       exp_sq [4];
    logic       exp_wr [4];
    exp_ph  = '{8'h40, 8'h80, 8'hC0, 8'h00};
    exp_saw = '{4'h4, 4'h8, 4'hC, 4'h0};
    exp_sq  = '{1'b0, 1'b1, 1'b1, 1'b0};
    exp_wr  = '{1'b0, 1'b0, 1'b0, 1'b1};
    send_word(8'h40, 1'b0);
    sample_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++;
      if (phase !== exp_ph[i] || saw !== exp_saw[i] || square !== exp_sq[i] || wrap !== exp_wr[i]) begin
        n_bad++;
        $display("FAIL basic_wrap[%0d]: got ph=%h saw=%h sq=%b wr=%b want ph=%h saw=%h sq=%b wr=%b",
                 i, phase, saw, square, wrap, exp_ph[i], exp_saw[i], exp_sq[i], exp_wr[i]);
      end
    end
    sample_en = 1'b0;
    step();
    n_cmp++;
    if (wrap !== 1'b0) begin n_bad++; $display("FAIL basic_wrap_pulse: got %b want 0", wrap); end
  endtask

  task automatic test_sweep();
    int wraps;
    int errs;
    errs = 0;
    for (int w = 0; w < 256; w++) begin
      clear_phase();
      send_word(w[7:0], 1'b0);
      wraps = 0;
      sample_en = 1'b1;
      for (int s = 0; s < 256; s++) begin
        step();
        if (wrap === 1'b1) wraps++;
      end
      sample_en = 1'b0;
      n_cmp++;
      if (wraps != w) begin
        n_bad++; errs++;
        if (errs < 5) $display("FAIL sweep_wraps word=%0d: got %0d want %0d", w, wraps, w);
      end
      n_cmp++;
      if (phase !== 8'h00) begin
        n_bad++; errs++;
        if (errs < 5) $display("FAIL sweep_phase word=%0d: got %h want 00", w, phase);
      end
    end
  endtask

  task automatic test_phase_continuous();
    clear_phase();
    send_word(8'h70, 1'b0);
    sample_en = 1'b1; step(); sample_en = 1'b0;
    send_word(8'h30, 1'b0);
    sample_en = 1'b1; step(); sample_en = 1'b0;
    n_cmp++;
    if (phase !== 8'hA0) begin n_bad++; $display("FAIL pc_setup: got %h want A0", phase); end
    send_word(8'h10, 1'b1);
    sample_en = 1'b1;
    step();
    n_cmp++;
    if (phase !== 8'hD0 || wrap !== 1'b0 || tune_ready !== 1'b0) begin
      n_bad++; $display("FAIL pc_first: got ph=%h wr=%b rdy=%b want D0/0/0", phase, wrap, tune_ready);
    end
    step();
    n_cmp++;
    if (phase !== 8'h00 || wrap !== 1'b1 || tune_ready !== 1'b1) begin
      n_bad++; $display("FAIL pc_wrap: got ph=%h wr=%b rdy=%b want 00/1/1", phase, wrap, tune_ready);
    end
    step();
    n_cmp++;
    if (phase !== 8'h10 || wrap !== 1'b0) begin n_bad++; $display("FAIL pc_new1: got ph=%h wr=%b want 10/0", phase, wrap); end
    step();
    n_cmp++;
    if (phase !== 8'h20) begin n_bad++; $display("FAIL pc_new2: got %h want 20", phase); end
    sample_en = 1'b0;
  endtask

  task automatic test_back_pressure();
    clear_phase();
    send_word(8'h11, 1'b0);
    tune_valid = 1'b1;
    tune_word  = 8'h22;
    tune_mode  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if (tune_ready !== 1'b0 || phase !== 8'h00) begin
        n_bad++; $display("FAIL bp_hold[%0d]: got rdy=%b ph=%h want 0/00", i, tune_ready, phase);
      end
    end
    sample_en = 1'b1;
    step();
    sample_en = 1'b0;
    n_cmp++;
    if (phase !== 8'h11 || tune_ready !== 1'b1) begin
      n_bad++; $display("FAIL bp_apply: got ph=%h rdy=%b want 11/1", phase, tune_ready);
    end
    step();
    tune_valid = 1'b0;
    n_cmp++;
    if (tune_ready !== 1'b0 || phase !== 8'h11) begin
      n_bad++; $display("FAIL bp_accept2: got rdy=%b ph=%h want 0/11", tune_ready, phase);
    end
    sample_en = 1'b1;
    step();
    sample_en = 1'b0;
    n_cmp++;
    if (phase !== 8'h33 || tune_ready !== 1'b1) begin
      n_bad++; $display("FAIL bp_second: got ph=%h rdy=%b want 33/1", phase, tune_ready);
    end
  endtask

  task automatic test_sync_clear();
    clear_phase();
    send_word(8'hD0, 1'b0);
    sample_en = 1'b1; step(); sample_en = 1'b0;
    send_word(8'h20, 1'b0);
    sample_en = 1'b1; step(); sample_en = 1'b0;
    n_cmp++;
    if (phase !== 8'hF0) begin n_bad++; $display("FAIL sc_setup: got %h want F0", phase); end
    send_word(8'h05, 1'b1);
    sample_en  = 1'b1;
    sync_clear = 1'b1;
    step();
    sync_clear = 1'b0;
    n_cmp++;
    if (phase !== 8'h00 || wrap !== 1'b0 || tune_ready !== 1'b1) begin
      n_bad++; $display("FAIL sc_clear: got ph=%h wr=%b rdy=%b want 00/0/1", phase, wrap, tune_ready);
    end
    step();
    sample_en = 1'b0;
    n_cmp++;
    if (phase !== 8'h05) begin n_bad++; $display("FAIL sc_newword: got %h want 05", phase); end
  endtask

  task automatic test_reset_mid();
    clear_phase();
    send_word(8'h40, 1'b0);
    sample_en = 1'b1; step(); sample_en = 1'b0;
    send_word(8'h10, 1'b1);
    sample_en = 1'b1; step(); sample_en = 1'b0;
    n_cmp++;
    if (phase !== 8'h80 || tune_ready !== 1'b0) begin
      n_bad++; $display("FAIL rm_setup: got ph=%h rdy=%b want 80/0", phase, tune_ready);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (phase !== 8'h00 || saw !== 4'h0 || square !== 1'b0 || wrap !== 1'b0 || tune_ready !== 1'b1) begin
      n_bad++; $display("FAIL rm_async: got ph=%h saw=%h sq=%b wr=%b rdy=%b want 00/0/0/0/1",
                        phase, saw, square, wrap, tune_ready);
    end
    #1 rst_n = 1'b1;
    sample_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (phase !== 8'h00 || wrap !== 1'b0) begin
        n_bad++; $display("FAIL rm_stopped[%0d]: got ph=%h wr=%b want 00/0", i, phase, wrap);
      end
    end
    sample_en = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    sample_en  = 1'b0;
    sync_clear = 1'b0;
    tune_valid = 1'b0;
    tune_word  = 8'h00;
    tune_mode  = 1'b0;
    #12;
    test_reset();
    rst_n = 1'b1;
    step();
    test_basic_wrap();
    test_phase_continuous();
    test_back_pressure();
    test_sync_clear();
    test_reset_mid();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
